// File: rtl/rf_pkg.sv
// rf_pkg: default register-file parameters and the register address type
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NR_READ_DEF = 2;
  localparam int NR_WRITE_DEF = 2;
  localparam int AW_DEF = $clog2(NREG_DEF);
  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-writer bits, set by issue and cleared by write
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [NREG-1:0] clr,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] busy_n;
  // write clears first so a same-cycle issue to the same register wins; x0 never busy
  always_comb begin
    busy_n = busy & ~clr;
    if (issue_valid) busy_n[issue_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end
  // busy state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_n;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard; define RF_BYPASS_EN for same-cycle write forwarding
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NR_READ = NR_READ_DEF,
  parameter int NR_WRITE = NR_WRITE_DEF,
  parameter int AW = $clog2(NREG)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NR_READ-1:0][AW-1:0]        i_raddr,
  output logic [NR_READ-1:0][XLEN-1:0]      o_rdata,
  output logic [NR_READ-1:0]                o_rbusy,
  input  logic [NR_WRITE-1:0]               i_we,
  input  logic [NR_WRITE-1:0][AW-1:0]       i_waddr,
  input  logic [NR_WRITE-1:0][XLEN-1:0]     i_wdata,
  input  logic                              i_issue_valid,
  input  logic [AW-1:0]                     i_issue_rd,
  output logic [NREG-1:0]                   o_busy_vec
);
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] clr;
  // one-hot clear of every register written this cycle
  always_comb begin
    clr = '0;
    for (int p = 0; p < NR_WRITE; p++)
      if (i_we[p]) clr[i_waddr[p]] = 1'b1;
  end
  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .issue_valid(i_issue_valid),
    .issue_rd(i_issue_rd),
    .clr(clr),
    .busy(o_busy_vec)
  );
  // data array; later ports overwrite earlier ones, x0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NR_WRITE; p++)
        if (i_we[p] && i_waddr[p] != '0) mem[i_waddr[p]] <= i_wdata[p];
    end
  // read ports from stored state, optionally overridden by the winning same-cycle write
  always_comb begin
    for (int p = 0; p < NR_READ; p++) begin
      o_rdata[p] = mem[i_raddr[p]];
      o_rbusy[p] = o_busy_vec[i_raddr[p]];
`ifdef RF_BYPASS_EN
      for (int q = 0; q < NR_WRITE; q++)
        if (i_we[q] && i_waddr[q] == i_raddr[p] && i_raddr[p] != '0) begin
          o_rdata[p] = i_wdata[q];
          o_rbusy[p] = i_issue_valid && i_issue_rd == i_raddr[p];
        end
`else
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors and corner sequences for regfile_mp in either build
module tb_regfile_mp;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk, rst_n, iv;
  logic [1:0][4:0] raddr, waddr;
  logic [1:0][31:0] rdata, wdata;
  logic [1:0] rbusy, we;
  logic [4:0] ird;
  logic [31:0] busy_vec;
  int n_chk, n_fail;

  typedef struct {
    logic [1:0] we;
    logic [4:0] wa0;
    logic [31:0] wd0;
    logic [4:0] wa1;
    logic [31:0] wd1;
    logic iv;
    logic [4:0] ird;
    logic [4:0] ra0, ra1;
    logic [31:0] e0, e1;
    logic eb0;
    logic [31:0] ebv;
  } vec_t;
  vec_t tv[8];

  regfile_mp dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata), .o_rbusy(rbusy),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_issue_valid(iv), .i_issue_rd(ird),
    .o_busy_vec(busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic v,
                       input logic [4:0] rd, input logic [4:0] r0, input logic [4:0] r1);
    we = w; waddr[0] = a0; wdata[0] = d0; waddr[1] = a1; wdata[1] = d1;
    iv = v; ird = rd; raddr[0] = r0; raddr[1] = r1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    tv[0] = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd6, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 32'h0};
    tv[1] = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0};
    tv[2] = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd7, 32'h0, 32'h22, 1'b0, 32'h0};
    tv[4] = '{2'b10, 5'd0, 32'h0, 5'd10, 32'hAAAA5555, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 1'b1, 32'h200};
    tv[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd10, 5'd9, 32'hAAAA5555, 32'h0, 1'b0, 32'h200};
    tv[6] = '{2'b11, 5'd31, 32'h80000001, 5'd1, 32'h1, 1'b0, 5'd0, 5'd0, 5'd10, 32'h0, 32'hAAAA5555, 1'b0, 32'h200};
    tv[7] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1, 32'h80000001, 32'h1, 1'b0, 32'h200};

    rst_n = 1'b0;
    drive(2'b11, 5'd3, 32'h1234, 5'd4, 32'h5678, 1'b1, 5'd3, 5'd0, 5'd0);
    #12;
    for (int a = 1; a < 32; a++) begin
      raddr[0] = 5'(a);
      #1;
      chk($sformatf("rst_x%0d", a), rdata[0], 32'h0);
    end
    chk("rst_busy", busy_vec, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].we, tv[i].wa0, tv[i].wd0, tv[i].wa1, tv[i].wd1, tv[i].iv, tv[i].ird, tv[i].ra0, tv[i].ra1);
      @(negedge clk);
      chk($sformatf("v%0d_rd0", i), rdata[0], tv[i].e0);
      chk($sformatf("v%0d_rd1", i), rdata[1], tv[i].e1);
      chk($sformatf("v%0d_rbusy0", i), 32'(rbusy[0]), 32'(tv[i].eb0));
      chk($sformatf("v%0d_busyvec", i), busy_vec, tv[i].ebv);
      tick();
    end

    drive(2'b01, 5'd12, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    @(negedge clk);
    chk("byp_x12_same", rdata[0], BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    drive(2'b11, 5'd13, 32'h11, 5'd13, 32'h22, 1'b0, 5'd0, 5'd12, 5'd13);
    @(negedge clk);
    chk("x12_next", rdata[0], 32'hDEADBEEF);
    chk("byp_x13_prio", rdata[1], BYP ? 32'h22 : 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd13);
    @(negedge clk);
    chk("x13_next", rdata[1], 32'h22);
    chk("x9_rbusy", 32'(rbusy[0]), 32'h1);
    tick();
    drive(2'b01, 5'd9, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    chk("x9_wr_rbusy", 32'(rbusy[0]), BYP ? 32'h0 : 32'h1);
    chk("x9_wr_rdata", rdata[0], BYP ? 32'h5 : 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    chk("x9_after_rbusy", 32'(rbusy[0]), 32'h0);
    chk("x9_after_rdata", rdata[0], 32'h5);
    chk("x9_after_busyvec", busy_vec, 32'h0);
    tick();

    drive(2'b01, 5'd3, 32'hA, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    @(negedge clk);
    chk("x3_iw_rdata", rdata[0], BYP ? 32'hA : 32'h0);
    chk("x3_iw_rbusy", 32'(rbusy[0]), BYP ? 32'h1 : 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0);
    @(negedge clk);
    chk("x3_next_rdata", rdata[0], 32'hA);
    chk("x3_next_rbusy", 32'(rbusy[0]), 32'h1);
    chk("x3_busyvec", busy_vec, 32'h8);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
    @(negedge clk);
    chk("x0_issue_busyvec", busy_vec, 32'h8);
    chk("x0_issue_rbusy", 32'(rbusy[0]), 32'h0);
    tick();

    drive(2'b10, 5'd0, 32'h0, 5'd4, 32'h99, 1'b1, 5'd4, 5'd4, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3);
    @(negedge clk);
    chk("x4_rdata", rdata[0], 32'h99);
    chk("x4_busyvec", busy_vec, 32'h18);
    #2;
    drive(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 1'b1, 5'd8, 5'd4, 5'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_x4", rdata[0], 32'h0);
    chk("midrst_x3", rdata[1], 32'h0);
    chk("midrst_busyvec", busy_vec, 32'h0);
    tick();
    chk("midrst_edge_x4", rdata[0], 32'h0);
    chk("midrst_edge_busyvec", busy_vec, 32'h0);
    rst_n = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd8);
    @(negedge clk);
    chk("postrst_x4", rdata[0], 32'h0);
    chk("postrst_busyvec", busy_vec, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
